mac_layer_sched: RTL and testbench

Sequencer that time-shares one MAC_ACC neuron datapath across all neurons of a network layer. For each neuron it fetches the weight vector and bias from a synchronous weight memory, holds the layer input vector, runs the MAC_ACC through its settle sequence, then captures the result, optionally applies ReLU, and emits it on a valid/ready output stream. It sits between the layer-level control and the MAC_ACC instance.

---
 rtl/mac_layer_sched.sv | 162 ++++++++++++++++
 tb/tb_mac_layer_sched.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_sched.sv
// Layer sequencer: time-shares one MAC_ACC neuron across a layer,
// fetching weights per neuron and streaming results out.
module mac_layer_sched #(
    parameter int MAX_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int WAIT_CYC    = 4,
    parameter int RELU        = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   layer_len,
    input  logic [127:0]      act_in,
    output logic              busy,
    output logic              done,
    output logic              w_rd_en,
    output logic [ADDR_W-1:0] w_addr,
    input  logic [127:0]      w_data,
    input  logic [7:0]        b_data,
    output logic [127:0]      mac_inA,
    output logic [127:0]      mac_inB,
    output logic [7:0]        mac_bias,
    output logic              mac_rdy,
    output logic              mac_rst,
    input  logic [21:0]       mac_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [21:0]       res_data,
    output logic [ADDR_W-1:0] res_idx
);

    localparam int CW = $clog2(WAIT_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT_CYC - 1);
    localparam logic [ADDR_W:0] LEN_MAX  = (ADDR_W + 1)'(MAX_NEURONS);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FETCH, S_RUN, S_CAPTURE, S_GAP, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [127:0]        ina_q, ina_d;
    logic [127:0]        inb_q, inb_d;
    logic [7:0]          bias_q, bias_d;
    logic [21:0]         res_q, res_d;
    logic                len_ok;
    logic                last_nrn;

    assign len_ok   = (layer_len != '0) && (layer_len <= LEN_MAX);
    assign last_nrn = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ina_q   <= '0;
            inb_q   <= '0;
            bias_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            bias_q  <= bias_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        ina_d     = ina_q;
        inb_d     = inb_q;
        bias_d    = bias_q;
        res_d     = res_q;
        busy      = 1'b1;
        done      = 1'b0;
        w_rd_en   = 1'b0;
        mac_rdy   = 1'b0;
        mac_rst   = 1'b1;
        res_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (len_ok) begin
                        ina_d   = act_in;
                        len_d   = layer_len;
                        idx_d   = '0;
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                w_rd_en = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                mac_rst = 1'b0;
                inb_d   = w_data;
                bias_d  = b_data;
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                mac_rst = 1'b0;
                mac_rdy = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // MSB set means a negative sum
                    if (RELU != 0 && mac_res[21]) res_d = '0;
                    else res_d = mac_res;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                mac_rst   = 1'b0;
                mac_rdy   = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    if (last_nrn) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_LOAD;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE) state_d = S_IDLE;
    end

    assign w_addr   = idx_q;
    assign res_idx  = idx_q;
    assign res_data = res_q;
    assign mac_inA  = ina_q;
    assign mac_inB  = inb_q;
    assign mac_bias = bias_q;

endmodule

// File: tb/tb_mac_layer_sched.sv
// Randomized bench for mac_layer_sched with a dot-product MAC stand-in
// and a cycle-level expectation model built from the layer rules.
module tb_mac_layer_sched;

    localparam int WAIT = 4;

    logic         clk = 1'b0;
    logic         rst, start, abort, res_ready;
    logic [4:0]   layer_len;
    logic [127:0] act_in, w_data;
    logic [7:0]   b_data;
    logic [21:0]  mac_res;

    logic         busy, done, w_rd_en, mac_rdy, mac_rst, res_valid;
    logic [3:0]   w_addr, res_idx;
    logic [127:0] mac_inA, mac_inB;
    logic [7:0]   mac_bias;
    logic [21:0]  res_data;

    logic         busy0, done0, w_rd_en0, mac_rdy0, mac_rst0, res_valid0;
    logic [3:0]   w_addr0, res_idx0;
    logic [127:0] mac_inA0, mac_inB0;
    logic [7:0]   mac_bias0;
    logic [21:0]  res_data0;

    logic [127:0] wmem [16];
    logic [7:0]   bmem [16];
    int           rdy_cnt = 0;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    mac_layer_sched #(.MAX_NEURONS(16), .ADDR_W(4), .WAIT_CYC(WAIT), .RELU(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_len(layer_len), .act_in(act_in), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_data(w_data), .b_data(b_data),
        .mac_inA(mac_inA), .mac_inB(mac_inB), .mac_bias(mac_bias),
        .mac_rdy(mac_rdy), .mac_rst(mac_rst), .mac_res(mac_res),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    mac_layer_sched #(.MAX_NEURONS(16), .ADDR_W(4), .WAIT_CYC(WAIT), .RELU(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .layer_len(layer_len), .act_in(act_in), .busy(busy0), .done(done0),
        .w_rd_en(w_rd_en0), .w_addr(w_addr0), .w_data(w_data), .b_data(b_data),
        .mac_inA(mac_inA0), .mac_inB(mac_inB0), .mac_bias(mac_bias0),
        .mac_rdy(mac_rdy0), .mac_rst(mac_rst0), .mac_res(mac_res),
        .res_valid(res_valid0), .res_ready(res_ready),
        .res_data(res_data0), .res_idx(res_idx0)
    );

    function automatic int neuron(input logic [127:0] a, input logic [127:0] w,
                                  input logic [7:0] b);
        int s;
        s = int'($signed(b));
        for (int i = 0; i < 16; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(w[8*i +: 8]));
        return s;
    endfunction

    function automatic logic [21:0] relu(input logic [21:0] v);
        return v[21] ? 22'd0 : v;
    endfunction

    // synchronous weight memory; junk when not read
    always @(posedge clk) begin
        if (w_rd_en) begin
            w_data <= wmem[w_addr];
            b_data <= bmem[w_addr];
        end else begin
            w_data <= {$urandom, $urandom, $urandom, $urandom};
            b_data <= 8'($urandom);
        end
    end

    // MAC stand-in: result only valid exactly at the settle point
    always @(posedge clk) rdy_cnt <= mac_rdy ? rdy_cnt + 1 : 0;
    always_comb begin
        mac_res = 22'h2AAAAA;
        if (mac_rdy && rdy_cnt == WAIT - 1)
            mac_res = 22'(neuron(mac_inA, mac_inB, mac_bias));
    end

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_layer(input int len, input int mode, input int abort_at);
        logic [127:0] act;
        logic [21:0]  raw [16];
        int nres, exp_n, exp_v, exp_d, cyc, bp;
        bit ok, prev_v, fin, bad;
        act = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            wmem[i] = {$urandom, $urandom, $urandom, $urandom};
            bmem[i] = (mode == 0) ? 8'(i + 1) : 8'($urandom);
        end
        ok    = (len >= 1 && len <= 16);
        exp_n = ok ? len : 0;
        for (int i = 0; i < exp_n; i++)
            raw[i] = 22'(neuron(act, wmem[i], bmem[i]));
        exp_v = ok ? 3 + WAIT : -1;
        exp_d = ok ? -1 : 1;
        @(negedge clk);
        act_in = act; layer_len = 5'(len);
        start = 1'b1; abort = 1'b0; res_ready = 1'b1;
        @(posedge clk);
        cyc = 1; nres = 0; bp = 0; prev_v = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            abort     = 1'b0;
            act_in    = {$urandom, $urandom, $urandom, $urandom};
            layer_len = 5'($urandom);
            start     = (abort_at < 0) && ($urandom % 4 == 0);
            if (cyc == 1) check("busy_on", busy, 1'b1);
            if (!ok) check("no_rd", w_rd_en, 1'b0);
            else if (w_rd_en) begin
                check("w_addr", w_addr, 128'(nres));
                check("w_cyc", 128'(cyc), 128'(exp_v - WAIT - 2));
            end
            res_ready = (mode == 1) ? (($urandom % 3) != 0) : 1'b1;
            if (res_valid) begin
                if (nres >= exp_n) begin
                    check("extra_res", 128'(nres), 128'(exp_n));
                end else begin
                    if (!prev_v) check("v_cyc", 128'(cyc), 128'(exp_v));
                    check("res_idx", res_idx, 128'(nres));
                    check("res_relu", res_data, relu(raw[nres]));
                    check("res_raw", res_data0, raw[nres]);
                    check("rdy_hold", mac_rdy, 1'b1);
                end
                if (mode == 2) res_ready = (bp >= 5);
                bp++;
                if (res_ready) begin
                    nres++;
                    exp_v = cyc + WAIT + 4;
                    if (nres == exp_n) exp_d = cyc + 1;
                end
            end
            prev_v = res_valid;
            if (done) begin
                check("done_cyc", 128'(cyc), 128'(exp_d));
                check("n_res", 128'(nres), 128'(exp_n));
                fin = 1;
            end
            if (abort_at == cyc) abort = 1'b1;
            if (abort_at >= 0 && cyc == abort_at + 1) begin
                check("ab_busy", busy, 1'b0);
                check("ab_valid", res_valid, 1'b0);
                check("ab_rdy", mac_rdy, 1'b0);
                check("ab_done", done, 1'b0);
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    bad |= res_valid | done | busy;
                end
                check("ab_quiet", bad, 1'b0);
                fin = 1;
            end
            if (!fin && cyc > 2000) begin
                check("timeout", 128'(cyc), 128'(0));
                fin = 1;
            end
            if (!fin) begin
                @(posedge clk);
                cyc++;
            end
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_done", done, 1'b0);
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        act_in = {$urandom, $urandom, $urandom, $urandom};
        layer_len = 5'd3; start = 1'b1; res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_rdy", mac_rdy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_valid", res_valid, 1'b0);
        check("rst_rdy", mac_rdy, 1'b0);
        check("rst_mrst", mac_rst, 1'b1);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_busy", busy, 1'b0);
        check("post_mrst", mac_rst, 1'b1);
        check("post_inA", mac_inA, 128'd0);
        check("post_res", res_data, 22'd0);
    endtask

    initial begin
        int len;
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1;
        layer_len = '0; act_in = '0;
        repeat (2) @(negedge clk);
        check("r_busy", busy, 1'b0);
        check("r_done", done, 1'b0);
        check("r_mrst", mac_rst, 1'b1);
        check("r_rdy", mac_rdy, 1'b0);
        check("r_valid", res_valid, 1'b0);
        check("r_rd", w_rd_en, 1'b0);
        check("r_inB", mac_inB, 128'd0);
        rst = 1'b0;
        @(negedge clk);
        run_layer(3, 0, -1);
        run_layer(3, 2, -1);
        run_layer(0, 0, -1);
        run_layer(20, 0, -1);
        run_layer(4, 0, 12);
        run_layer(1, 0, -1);
        reset_mid_run();
        for (int t = 0; t < 12; t++) begin
            if ($urandom % 6 == 0) len = ($urandom % 2) ? 0 : int'($urandom_range(17, 31));
            else len = int'($urandom_range(1, 16));
            run_layer(len, 1, -1);
        end
        run_layer(16, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
